// File: rtl/valve_frame_assembler_pkg.sv
// ---------------------------------------------------------------------------
// valve_frame_assembler_pkg : character codes, FSM states, error bit indices
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package valve_frame_assembler_pkg;

  localparam logic [1:0] CODE_ZERO   = 2'b00;
  localparam logic [1:0] CODE_ONE    = 2'b01;
  localparam logic [1:0] CODE_COMMIT = 2'b10;
  localparam logic [1:0] CODE_OTHER  = 2'b11;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_FULL  = 2;

endpackage

`default_nettype wire

// File: rtl/valve_frame_assembler.sv
// ---------------------------------------------------------------------------
// valve_frame_assembler : builds valve words from decoded chars, commits on 'm'
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module valve_frame_assembler
  import valve_frame_assembler_pkg::*;
#(
  parameter int NUM_VALVES = 24,
  parameter int DEPTH      = 64,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  code_valid,
  input  logic [1:0]            code,
  input  logic                  rewind,
  input  logic                  clr_err,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [NUM_VALVES-1:0] mem_wdata,
  output logic [ADDR_W:0]       word_count,
  output logic                  full,
  output logic [2:0]            err
);

  localparam int CW = $clog2(NUM_VALVES + 1);
  localparam logic [CW-1:0]     c_NV    = CW'(NUM_VALVES);
  localparam logic [CW-1:0]     c_ONE   = CW'(1);
  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);

  state_t                  r_state, w_state_nxt;
  logic [NUM_VALVES-1:0]   r_shreg, w_shreg_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic                    w_commit;
  logic [2:0]              w_err_set;
  logic                    w_full;
  logic                    w_is_bit;

  logic                    r_mem_we;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [NUM_VALVES-1:0]   r_mem_wdata;
  logic [ADDR_W:0]         r_word_count;
  logic [2:0]              r_err;

  assign w_full   = (r_word_count == c_DEPTH);
  assign w_is_bit = (code == CODE_ZERO) || (code == CODE_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_err_set   = 3'b000;

    // rewind takes priority and swallows any character arriving with it
    if (rewind) begin
      w_state_nxt = ST_COLLECT;
      w_shreg_nxt = '0;
      w_cnt_nxt   = '0;
    end else if (code_valid) begin
      if (r_state == ST_COLLECT) begin
        if (w_is_bit) begin
          if (r_cnt == c_NV) begin
            w_err_set[ERR_LONG] = 1'b1;
            w_shreg_nxt         = '0;
            w_cnt_nxt           = '0;
            w_state_nxt         = ST_DISCARD;
          end else begin
            w_shreg_nxt = {r_shreg[NUM_VALVES-2:0], code[0]};
            w_cnt_nxt   = r_cnt + c_ONE;
          end
        end else if (code == CODE_COMMIT) begin
          if (r_cnt == c_NV) begin
            if (w_full) begin
              w_err_set[ERR_FULL] = 1'b1;
            end else begin
              w_commit = 1'b1;
            end
          end else if (r_cnt != '0) begin
            w_err_set[ERR_SHORT] = 1'b1;
          end
          w_shreg_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end else if (code == CODE_COMMIT) begin
        w_state_nxt = ST_COLLECT;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_word_count <= '0;
      r_err        <= 3'b000;
    end else begin
      r_shreg  <= w_shreg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mem_we <= w_commit;
      // the write pointer is the low bits of the count; it never wraps
      if (w_commit) begin
        r_mem_addr  <= r_word_count[ADDR_W-1:0];
        r_mem_wdata <= r_shreg;
      end
      if (rewind) begin
        r_word_count <= '0;
      end else if (w_commit) begin
        r_word_count <= r_word_count + (ADDR_W + 1)'(1);
      end
      r_err <= (clr_err ? 3'b000 : r_err) | w_err_set;
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign word_count = r_word_count;
  assign full       = w_full;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_valve_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_valve_frame_assembler : scenario tasks plus randomized frames vs a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_valve_frame_assembler;

  localparam int NV = 4;
  localparam int DEPTH = 2;
  localparam int AW = $clog2(DEPTH);
  localparam int W = 1 + AW + NV + (AW + 1) + 1 + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            code_valid = 1'b0;
  logic [1:0]      code = 2'b00;
  logic            rewind = 1'b0;
  logic            clr_err = 1'b0;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [NV-1:0]   mem_wdata;
  logic [AW:0]     word_count;
  logic            full;
  logic [2:0]      err;

  int n_vec = 0;
  int n_fail = 0;

  valve_frame_assembler #(.NUM_VALVES(NV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
    .rewind(rewind), .clr_err(clr_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: frame kept as a list of received bits
  bit            m_frame[$];
  bit            m_disc;
  int            m_count;
  logic [2:0]    m_err;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [NV-1:0] m_wdata;

  task automatic model_step(input byte ch, input bit clr, input bit rw);
    logic [2:0] es;
    es = 3'b000;
    m_we = 1'b0;
    if (ch == "R") begin
      m_frame.delete(); m_disc = 0; m_count = 0; m_err = 3'b000;
      m_addr = '0; m_wdata = '0;
      return;
    end
    if (rw) begin
      m_frame.delete(); m_disc = 0; m_count = 0;
    end else if (ch == "0" || ch == "1") begin
      if (!m_disc) begin
        if (m_frame.size() == NV) begin
          es[1] = 1'b1; m_frame.delete(); m_disc = 1;
        end else begin
          m_frame.push_back(ch == "1");
        end
      end
    end else if (ch == "m") begin
      if (m_disc) begin
        m_disc = 0;
      end else if (m_frame.size() == NV) begin
        if (m_count < DEPTH) begin
          m_we = 1'b1;
          m_addr = m_count[AW-1:0];
          for (int i = 0; i < NV; i++) m_wdata[NV-1-i] = m_frame[i];
          m_count++;
        end else begin
          es[2] = 1'b1;
        end
      end else if (m_frame.size() > 0) begin
        es[0] = 1'b1;
      end
      m_frame.delete();
    end
    m_err = (clr ? 3'b000 : m_err) | es;
  endtask

  function automatic logic [W-1:0] exp_vec();
    logic [AW:0] c;
    c = m_count[AW:0];
    return {m_we, m_addr, m_wdata, c, (m_count == DEPTH), m_err};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {mem_we, mem_addr, mem_wdata, word_count, full, err};
  endfunction

  // ch: '0','1','m','x' (other), '.' idle, 'R' reset
  task automatic drive(input byte ch, input bit clr, input bit rw);
    rst        = (ch == "R");
    code_valid = (ch == "0" || ch == "1" || ch == "m" || ch == "x");
    code       = (ch == "0") ? 2'b00 : (ch == "1") ? 2'b01 :
                 (ch == "m") ? 2'b10 : (ch == "x") ? 2'b11 : 2'($urandom);
    clr_err    = clr;
    rewind     = rw;
    @(posedge clk);
    #1;
    model_step(ch, clr, rw);
    rst = 1'b0; code_valid = 1'b0; clr_err = 1'b0; rewind = 1'b0;
  endtask

  task automatic test_reset();
    drive("R", 0, 0);
    drive("R", 0, 0);
    n_vec++;
    if (obs_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs_vec(), {W{1'b0}});
    end
  endtask

  task automatic test_basic();
    string s = "1011m";
    drive("R", 0, 0);
    foreach (s[i]) begin
      drive(s[i], 0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, word_count} !== {1'b1, 1'b0, 4'b1011, 2'd1}) begin
      n_fail++;
      $display("FAIL basic_write: got %b %b %b %0d expected 1 0 1011 1",
               mem_we, mem_addr, mem_wdata, word_count);
    end
    drive(".", 0, 0);
    n_vec++;
    if (mem_we !== 1'b0 || mem_wdata !== 4'b1011) begin
      n_fail++;
      $display("FAIL basic_hold: we %b data %b expected 0 1011", mem_we, mem_wdata);
    end
  endtask

  task automatic test_short();
    string s = "11m0110m";
    drive("R", 0, 0);
    foreach (s[i]) begin
      drive(s[i], 0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL short[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, err} !== {1'b1, 1'b0, 4'b0110, 3'b001}) begin
      n_fail++;
      $display("FAIL short_write: got we %b addr %b data %b err %b expected 1 0 0110 001",
               mem_we, mem_addr, mem_wdata, err);
    end
  endtask

  task automatic test_long();
    string s = "101010m1111m";
    drive("R", 0, 0);
    foreach (s[i]) begin
      drive(s[i], 0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL long[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, err, word_count} !== {1'b1, 1'b0, 4'b1111, 3'b010, 2'd1}) begin
      n_fail++;
      $display("FAIL long_write: got we %b addr %b data %b err %b cnt %0d expected 1 0 1111 010 1",
               mem_we, mem_addr, mem_wdata, err, word_count);
    end
  endtask

  task automatic test_full();
    string s = "1010m0101m1111m";
    string t = "0011m";
    drive("R", 0, 0);
    foreach (s[i]) begin
      drive(s[i], 0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({mem_we, full, word_count, err, mem_addr, mem_wdata} !== {1'b0, 1'b1, 2'd2, 3'b100, 1'b1, 4'b0101}) begin
      n_fail++;
      $display("FAIL full_refuse: got we %b full %b cnt %0d err %b addr %b data %b expected 0 1 2 100 1 0101",
               mem_we, full, word_count, err, mem_addr, mem_wdata);
    end
    drive("1", 0, 1);
    foreach (t[i]) begin
      drive(t[i], 0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rewind[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, word_count, full, err} !== {1'b1, 1'b0, 4'b0011, 2'd1, 1'b0, 3'b100}) begin
      n_fail++;
      $display("FAIL rewind_write: got we %b addr %b data %b cnt %0d full %b err %b expected 1 0 0011 1 0 100",
               mem_we, mem_addr, mem_wdata, word_count, full, err);
    end
  endtask

  task automatic test_other();
    string s = "x0x1x1x1xxxm";
    drive("R", 0, 0);
    foreach (s[i]) begin
      drive(s[i], 0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL other[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({mem_we, mem_wdata} !== {1'b1, 4'b0111}) begin
      n_fail++;
      $display("FAIL other_write: got we %b data %b expected 1 0111", mem_we, mem_wdata);
    end
    drive("m", 0, 0);
    n_vec++;
    if ({mem_we, err, word_count} !== {1'b0, 3'b000, 2'd1}) begin
      n_fail++;
      $display("FAIL lone_m: got we %b err %b cnt %0d expected 0 000 1", mem_we, err, word_count);
    end
  endtask

  task automatic test_rst_midframe();
    string s = "1001m";
    drive("R", 0, 0);
    drive("1", 0, 0);
    drive("1", 0, 0);
    drive("R", 0, 0);
    n_vec++;
    if (obs_vec() !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got %h expected %h", obs_vec(), {W{1'b0}});
    end
    foreach (s[i]) begin
      drive(s[i], 0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_mid[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata, err} !== {1'b1, 1'b0, 4'b1001, 3'b000}) begin
      n_fail++;
      $display("FAIL rst_mid_write: got we %b addr %b data %b err %b expected 1 0 1001 000",
               mem_we, mem_addr, mem_wdata, err);
    end
  endtask

  task automatic test_clr_err();
    string s = "11111m11";
    drive("R", 0, 0);
    foreach (s[i]) drive(s[i], 0, 0);
    n_vec++;
    if (err !== 3'b010) begin
      n_fail++;
      $display("FAIL clr_pre: err %b expected 010", err);
    end
    drive("m", 1, 0);
    n_vec++;
    if (err !== 3'b001) begin
      n_fail++;
      $display("FAIL clr_with_event: err %b expected 001", err);
    end
    drive(".", 1, 0);
    n_vec++;
    if (err !== 3'b000) begin
      n_fail++;
      $display("FAIL clr_only: err %b expected 000", err);
    end
  endtask

  task automatic test_random();
    drive("R", 0, 0);
    for (int f = 0; f < 60; f++) begin
      int len;
      len = ($urandom_range(0, 1) == 1) ? NV : int'($urandom_range(0, NV + 2));
      for (int k = 0; k <= len; k++) begin
        byte ch;
        bit clr, rw;
        if (k == len) ch = "m";
        else ch = ($urandom_range(0, 1) == 1) ? "1" : "0";
        if ($urandom_range(0, 4) == 0) begin
          drive(($urandom_range(0, 1) == 1) ? "x" : ".", 0, 0);
          n_vec++;
          if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_gap f%0d: got %h expected %h", f, obs_vec(), exp_vec());
          end
        end
        clr = ($urandom_range(0, 19) == 0);
        rw  = ($urandom_range(0, 29) == 0);
        drive(ch, clr, rw);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random f%0d k%0d ch %s: got %h expected %h",
                   f, k, ch, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_full();
    test_other();
    test_rst_midframe();
    test_clr_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
